act_unit_mv3: RTL

ACT_UNIT_MV3 -- requirements
Module: act_unit_mv3

---
 rtl/act_pkg.sv | 17 +
 rtl/act_lane.sv | 106 ++++++++++
 rtl/act_unit_mv3.sv | 53 +++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared constants for the activation unit: mode codes, the 1/6 reciprocal
// and the pipeline depth.
package act_pkg;

    typedef enum logic [2:0] {
        MODE_BYPASS = 3'd0,
        MODE_RELU   = 3'd1,
        MODE_RELU6  = 3'd2,
        MODE_HSIG   = 3'd3,
        MODE_HSWISH = 3'd4
    } act_mode_e;

    localparam int INV6      = 10923;
    localparam int INV6_FRAC = 16;
    localparam int STAGES    = 4;

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath: four stall-able stages ending in a
// saturated OUT_WIDTH result register.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 18,
    parameter int FRAC_BITS  = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic [2:0]                   mode,
    output logic signed [OUT_WIDTH-1:0]  y
);

    localparam int TW = DATA_WIDTH + 2;
    localparam int MW = DATA_WIDTH + TW;
    localparam int PW = MW + INV6_FRAC + 1;

    localparam logic signed [TW-1:0] THREE    = TW'(64'sd3 << FRAC_BITS);
    localparam logic signed [TW-1:0] SIX      = TW'(64'sd6 << FRAC_BITS);
    localparam logic signed [PW-1:0] INV6_P   = PW'(INV6);
    localparam logic signed [PW-1:0] HALF_SW  = PW'(1) << (FRAC_BITS + INV6_FRAC - 1);
    localparam logic signed [PW-1:0] HALF_SG  = PW'(1) << (INV6_FRAC - 1);
    localparam logic signed [PW-1:0] OUT_MAX  = (PW'(1) << (OUT_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] OUT_MIN  = -(PW'(1) << (OUT_WIDTH - 1));

    // stage 1: capture
    logic signed [DATA_WIDTH-1:0] x1;
    logic [2:0]                   m1;
    always_ff @(posedge clk) begin
        if (en) begin
            x1 <= x;
            m1 <= mode;
        end
    end

    // stage 2: T = clamp(x+3, 0, 6) and the piecewise-linear modes
    logic signed [TW-1:0] xe1, sum1, t1c, lin1c;
    always_comb begin
        xe1  = {{2{x1[DATA_WIDTH-1]}}, x1};
        sum1 = xe1 + THREE;
        t1c  = sum1[TW-1] ? '0 : (sum1 > SIX) ? SIX : sum1;
        case (m1)
            MODE_RELU:  lin1c = xe1[TW-1] ? '0 : xe1;
            MODE_RELU6: lin1c = xe1[TW-1] ? '0 : (xe1 > SIX) ? SIX : xe1;
            default:    lin1c = xe1;
        endcase
    end

    logic signed [DATA_WIDTH-1:0] x2;
    logic signed [TW-1:0]         t2, lin2;
    logic [2:0]                   m2;
    always_ff @(posedge clk) begin
        if (en) begin
            x2   <= x1;
            t2   <= t1c;
            lin2 <= lin1c;
            m2   <= m1;
        end
    end

    // stage 3: x*T for hard-swish, T alone for hard-sigmoid
    logic signed [MW-1:0] xm, tm, mul2c;
    always_comb begin
        xm    = {{(MW-DATA_WIDTH){x2[DATA_WIDTH-1]}}, x2};
        tm    = {{(MW-TW){t2[TW-1]}}, t2};
        mul2c = (m2 == MODE_HSWISH) ? xm * tm : tm;
    end

    logic signed [MW-1:0] mul3;
    logic signed [TW-1:0] lin3;
    logic [2:0]           m3;
    always_ff @(posedge clk) begin
        if (en) begin
            mul3 <= mul2c;
            lin3 <= lin2;
            m3   <= m2;
        end
    end

    // stage 4: scale by 1/6, round half-up back to FRAC_BITS, saturate
    logic signed [PW-1:0]        mul_p, prod, lin_p, val;
    logic signed [OUT_WIDTH-1:0] sat;
    always_comb begin
        mul_p = {{(PW-MW){mul3[MW-1]}}, mul3};
        lin_p = {{(PW-TW){lin3[TW-1]}}, lin3};
        prod  = mul_p * INV6_P;
        case (m3)
            MODE_HSWISH: val = (prod + HALF_SW) >>> (FRAC_BITS + INV6_FRAC);
            MODE_HSIG:   val = (prod + HALF_SG) >>> INV6_FRAC;
            default:     val = lin_p;
        endcase
        if (val > OUT_MAX)      sat = OUT_MAX[OUT_WIDTH-1:0];
        else if (val < OUT_MIN) sat = OUT_MIN[OUT_WIDTH-1:0];
        else                    sat = val[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    y <= '0;
        else if (en) y <= sat;
    end

endmodule

// File: rtl/act_unit_mv3.sv
// Multi-lane activation unit: LANES parallel act_lane datapaths sharing one
// valid pipeline and one global stall.
module act_unit_mv3
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 18,
    parameter int FRAC_BITS  = 9,
    parameter int LANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [2:0]                    in_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic [STAGES:1]                 vld_pipe;
    logic                            en;
    logic [LANES-1:0][OUT_WIDTH-1:0] lane_y;

    // a held output freezes the whole pipe, bubbles included
    assign en       = !(vld_pipe[STAGES] && !out_ready);
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .x   (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .mode(in_mode),
            .y   (lane_y[g])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = out_valid ? lane_y : '0;

endmodule
